// File: rtl/lcd_panel_receiver_pkg.sv
// lcd_pkg: command bytes, character range and FSM states for the LCD panel receiver
package lcd_pkg;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_SETADDR_MASK = 8'h80;
  localparam logic [7:0] CHAR_SPACE       = 8'h20;
  localparam logic [7:0] CHAR_MIN         = 8'h20;
  localparam logic [7:0] CHAR_MAX         = 8'h7E;
  typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHAR_MIN) && (b <= CHAR_MAX);
  endfunction
endpackage

// File: rtl/lcd_panel_receiver_if.sv
// lcd_panel_receiver_if: panel bus, readback port and status signals
interface lcd_panel_receiver_if #(parameter int ADDR_W = 5);
  logic [7:0]        lcd_data;
  logic              lcd_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_char;
  logic [ADDR_W-1:0] cursor;
  logic              busy;
  logic              char_valid;
  logic [7:0]        char_out;
  logic [ADDR_W-1:0] char_addr;
  logic              err_illegal;
  logic              err_overrun;
  modport master (
    output lcd_data, lcd_enable, rd_addr,
    input  rd_char, cursor, busy, char_valid, char_out, char_addr, err_illegal, err_overrun
  );
  modport slave (
    input  lcd_data, lcd_enable, rd_addr,
    output rd_char, cursor, busy, char_valid, char_out, char_addr, err_illegal, err_overrun
  );
endinterface

// File: rtl/lcd_panel_receiver_ddram.sv
// lcd_ddram: single-write-port display RAM with a registered read-first read port
module lcd_ddram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [DEPTH];
  // storage is not reset; the receiver's clear sequence initialises it
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // read register sees the pre-write contents on a same-address collision
  always_ff @(posedge clk)
    if (reset) o_rdata <= '0;
    else o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/lcd_panel_receiver.sv
// lcd_panel_receiver: decodes lcd_enable strobes into a character buffer with cursor
module lcd_panel_receiver
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int ADDR_W      = 5,
  parameter int BUSY_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  lcd_panel_receiver_if.slave bus
);
  localparam int DEPTH = COLS * ROWS;
  localparam int CNT_W = BUSY_CYCLES > 1 ? $clog2(BUSY_CYCLES) : 1;
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr, r_cursor, r_char_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_en_q, r_pend, r_char_valid, r_err_illegal, r_err_overrun;
  logic [7:0]        r_data_q, r_char_out;
  logic              w_busy, w_strobe, w_print, w_setaddr, w_clear, w_home, w_illegal, w_we;
  logic [ADDR_W-1:0] w_waddr, w_cursor_inc;
  logic [7:0]        w_wdata;
  // data_q only moves while enable is high, so it still holds the byte one cycle after the strobe
  always_comb begin
    w_busy       = r_state != IDLE;
    w_strobe     = r_en_q & ~bus.lcd_enable;
    w_print      = r_pend & is_printable(r_data_q);
    w_setaddr    = r_pend & r_data_q[7] & (int'(r_data_q[6:0]) < DEPTH);
    w_clear      = r_pend & (r_data_q == CMD_CLEAR);
    w_home       = r_pend & (r_data_q == CMD_HOME);
    w_illegal    = r_pend & ~(w_print | w_setaddr | w_clear | w_home);
    w_we         = (r_state == CLEAR) | w_print;
    w_waddr      = r_state == CLEAR ? r_clr_addr : r_cursor;
    w_wdata      = r_state == CLEAR ? CHAR_SPACE : r_data_q;
    w_cursor_inc = r_cursor == ADDR_W'(DEPTH - 1) ? '0 : r_cursor + 1'b1;
  end
  // strobe detection; a strobe seen while busy is dropped and flagged
  always_ff @(posedge clk)
    if (reset) begin
      r_en_q        <= 1'b0;
      r_data_q      <= '0;
      r_pend        <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_en_q <= bus.lcd_enable;
      if (bus.lcd_enable) r_data_q <= bus.lcd_data;
      r_pend <= w_strobe & ~w_busy;
      if (w_strobe & w_busy) r_err_overrun <= 1'b1;
    end
  // control FSM: clear fill, post-clear busy time, and cursor updates while idle
  always_ff @(posedge clk)
    if (reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_cnt      <= '0;
      r_cursor   <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_clear) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
          end else if (w_home) r_cursor <= '0;
          else if (w_setaddr) r_cursor <= r_data_q[ADDR_W-1:0];
          else if (w_print) r_cursor <= w_cursor_inc;
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
            r_state    <= BUSY;
            r_clr_addr <= '0;
            r_cnt      <= '0;
            r_cursor   <= '0;
          end
        end
        BUSY:
          if (r_cnt == CNT_W'(BUSY_CYCLES - 1)) r_state <= IDLE;
          else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
  // character pulse outputs and sticky illegal-byte flag
  always_ff @(posedge clk)
    if (reset) begin
      r_char_valid  <= 1'b0;
      r_char_out    <= '0;
      r_char_addr   <= '0;
      r_err_illegal <= 1'b0;
    end else begin
      r_char_valid <= w_print;
      if (w_print) begin
        r_char_out  <= r_data_q;
        r_char_addr <= r_cursor;
      end
      if (w_illegal) r_err_illegal <= 1'b1;
    end
  lcd_ddram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ddram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_char)
  );
  assign bus.cursor      = r_cursor;
  assign bus.busy        = w_busy;
  assign bus.char_valid  = r_char_valid;
  assign bus.char_out    = r_char_out;
  assign bus.char_addr   = r_char_addr;
  assign bus.err_illegal = r_err_illegal;
  assign bus.err_overrun = r_err_overrun;
endmodule

// File: tb/tb_lcd_panel_receiver.sv
// tb_lcd_panel_receiver: directed checks of strobe decode, buffer, cursor, clear and errors
module tb_lcd_panel_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  lcd_panel_receiver_if #(.ADDR_W(5)) bus ();
  lcd_panel_receiver dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [7:0] b);
    bus.lcd_data = b;
    bus.lcd_enable = 1'b1;
    tick();
    bus.lcd_enable = 1'b0;
    tick();
    tick();
  endtask
  task automatic rd(input int a, output logic [7:0] d);
    bus.rd_addr = 5'(a);
    tick();
    d = bus.rd_char;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    int n, bad;
    logic [7:0] d;
    bus.lcd_enable = 1'b1;
    bus.lcd_data = 8'h41;
    bus.rd_addr = '0;
    reset = 1'b1;
    tick();
    tick();
    total++; if (bus.char_valid !== 1'b0 || bus.cursor !== 5'd0 || bus.rd_char !== 8'h00 || bus.char_out !== 8'h00)
      $display("FAIL reset_outputs: valid=%b cursor=%0d rd=%h out=%h, want 0", bus.char_valid, bus.cursor, bus.rd_char, bus.char_out); else passed++;
    reset = 1'b0;
    bus.lcd_enable = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL reset_busy_high: got %b want 1", bus.busy); else passed++;
    wait_idle(n);
    total++; if (n !== 36) $display("FAIL reset_busy_len: got %0d cycles want 36", n); else passed++;
    total++; if (bus.err_overrun !== 1'b0 || bus.err_illegal !== 1'b0)
      $display("FAIL reset_errors: ovr=%b ill=%b want 0 0", bus.err_overrun, bus.err_illegal); else passed++;
    total++; if (bus.cursor !== 5'd0) $display("FAIL reset_cursor: got %0d want 0", bus.cursor); else passed++;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd(a, d);
      if (d !== 8'h20) bad++;
    end
    total++; if (bad !== 0) $display("FAIL reset_fill: %0d addresses not 0x20, want 0", bad); else passed++;
  endtask
  task automatic test_chars();
    logic [7:0] d;
    strobe(8'h48);
    total++; if (bus.char_valid !== 1'b1 || bus.char_out !== 8'h48 || bus.char_addr !== 5'd0)
      $display("FAIL char_h: valid=%b out=%h addr=%0d want 1 48 0", bus.char_valid, bus.char_out, bus.char_addr); else passed++;
    tick();
    total++; if (bus.char_valid !== 1'b0) $display("FAIL char_pulse_width: got %b want 0", bus.char_valid); else passed++;
    strobe(8'h49);
    total++; if (bus.char_valid !== 1'b1 || bus.char_out !== 8'h49 || bus.char_addr !== 5'd1)
      $display("FAIL char_i: valid=%b out=%h addr=%0d want 1 49 1", bus.char_valid, bus.char_out, bus.char_addr); else passed++;
    total++; if (bus.cursor !== 5'd2) $display("FAIL char_cursor: got %0d want 2", bus.cursor); else passed++;
    rd(0, d);
    total++; if (d !== 8'h48) $display("FAIL buf0: got %h want 48", d); else passed++;
    rd(1, d);
    total++; if (d !== 8'h49) $display("FAIL buf1: got %h want 49", d); else passed++;
  endtask
  task automatic test_setaddr_home();
    logic [7:0] d;
    strobe(8'h90);
    total++; if (bus.cursor !== 5'd16 || bus.char_valid !== 1'b0)
      $display("FAIL setaddr: cursor=%0d valid=%b want 16 0", bus.cursor, bus.char_valid); else passed++;
    strobe(8'h41);
    total++; if (bus.char_addr !== 5'd16 || bus.cursor !== 5'd17)
      $display("FAIL setaddr_write: addr=%0d cursor=%0d want 16 17", bus.char_addr, bus.cursor); else passed++;
    rd(16, d);
    total++; if (d !== 8'h41) $display("FAIL buf16: got %h want 41", d); else passed++;
    strobe(8'h9F);
    total++; if (bus.cursor !== 5'd31) $display("FAIL setaddr_max: got %0d want 31", bus.cursor); else passed++;
    strobe(8'h02);
    total++; if (bus.cursor !== 5'd0 || bus.busy !== 1'b0)
      $display("FAIL home: cursor=%0d busy=%b want 0 0", bus.cursor, bus.busy); else passed++;
  endtask
  task automatic test_wrap();
    logic [7:0] d;
    int bad = 0;
    for (int i = 0; i < 33; i++) begin
      strobe(8'(8'h21 + i));
      if (bus.char_valid !== 1'b1 || bus.char_addr !== 5'(i % 32)) bad++;
    end
    total++; if (bad !== 0) $display("FAIL wrap_addrs: %0d bad pulses want 0", bad); else passed++;
    total++; if (bus.cursor !== 5'd1) $display("FAIL wrap_cursor: got %0d want 1", bus.cursor); else passed++;
    rd(0, d);
    total++; if (d !== 8'h41) $display("FAIL wrap_buf0: got %h want 41", d); else passed++;
    rd(31, d);
    total++; if (d !== 8'h40) $display("FAIL wrap_buf31: got %h want 40", d); else passed++;
  endtask
  task automatic test_illegal();
    logic [7:0] d;
    int pulses = 0;
    logic [7:0] bytes [3];
    bytes[0] = 8'h05;
    bytes[1] = 8'hA0;
    bytes[2] = 8'h7F;
    total++; if (bus.err_illegal !== 1'b0) $display("FAIL illegal_pre: got %b want 0", bus.err_illegal); else passed++;
    for (int i = 0; i < 3; i++) begin
      strobe(bytes[i]);
      if (bus.char_valid !== 1'b0) pulses++;
    end
    total++; if (bus.err_illegal !== 1'b1) $display("FAIL illegal_flag: got %b want 1", bus.err_illegal); else passed++;
    total++; if (pulses !== 0) $display("FAIL illegal_pulse: %0d pulses want 0", pulses); else passed++;
    total++; if (bus.cursor !== 5'd1) $display("FAIL illegal_cursor: got %0d want 1", bus.cursor); else passed++;
    rd(0, d);
    total++; if (d !== 8'h41) $display("FAIL illegal_buf0: got %h want 41", d); else passed++;
  endtask
  task automatic test_clear_overrun();
    logic [7:0] d;
    int n, bad;
    total++; if (bus.err_overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", bus.err_overrun); else passed++;
    strobe(8'h01);
    total++; if (bus.busy !== 1'b1) $display("FAIL clear_busy: got %b want 1", bus.busy); else passed++;
    repeat (10) tick();
    strobe(8'h58);
    total++; if (bus.err_overrun !== 1'b1 || bus.char_valid !== 1'b0)
      $display("FAIL overrun: ovr=%b valid=%b want 1 0", bus.err_overrun, bus.char_valid); else passed++;
    wait_idle(n);
    total++; if (bus.busy !== 1'b0) $display("FAIL clear_timeout: busy=%b after %0d cycles", bus.busy, n); else passed++;
    total++; if (bus.cursor !== 5'd0 || bus.err_illegal !== 1'b1)
      $display("FAIL clear_state: cursor=%0d ill=%b want 0 1", bus.cursor, bus.err_illegal); else passed++;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd(a, d);
      if (d !== 8'h20) bad++;
    end
    total++; if (bad !== 0) $display("FAIL clear_fill: %0d addresses not 0x20, want 0", bad); else passed++;
  endtask
  task automatic test_back_to_back();
    strobe(8'h4B);
    strobe(8'h4C);
    total++; if (bus.char_valid !== 1'b1 || bus.char_out !== 8'h4C || bus.char_addr !== 5'd1 || bus.cursor !== 5'd2)
      $display("FAIL back_to_back: valid=%b out=%h addr=%0d cursor=%0d want 1 4c 1 2", bus.char_valid, bus.char_out, bus.char_addr, bus.cursor); else passed++;
  endtask
  initial begin
    bus.lcd_data = '0;
    bus.lcd_enable = 1'b0;
    bus.rd_addr = '0;
    test_reset();
    test_chars();
    test_setaddr_home();
    test_wrap();
    test_illegal();
    test_clear_overrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
